// File: rtl/adxl357_i2c_sequencer.sv
// adxl357_i2c_sequencer
//   Sequencer/arbiter in front of the ADXL357 I2C controller.
//   - After reset and a power-up delay, it writes the three-entry init table
//     (RANGE, FILTER, POWER_CTL=measure) in CPU single-byte mode.
//   - It then switches the controller to HW burst mode and passes DRDY through.
//   - Host single-register writes are arbitrated against DRDY-driven bursts.
//     A DRDY edge that arrives while the gate is closed is replayed once.
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_drdy          synchronised ADXL357 DRDY
//   i_status        controller status: [0] ready, [1] finish, [9:2] state
//   i_host_req      host write request (level, held until o_host_ack)
//   i_host_reg      host register address
//   i_host_data     host write data
//   o_ctrl          [0] enable, [1] rw_reg, [3:2] op_mode, [6:4] clk_rate
//   o_dev_addr      fixed 7-bit device address
//   o_reg_addr      register address for the current CPU-mode write
//   o_w_data        data byte for the current CPU-mode write
//   o_drdy          gated DRDY towards the controller
//   o_init_done     init table complete
//   o_host_ack      one-cycle pulse when a host write completes
//   o_err           sticky watchdog error
//   o_sample_cnt    completed burst reads (wrapping)
//   o_seq_state     FSM state for debug
//
// Build option
//   SEQ_TIMEOUT_EN  enables the per-transaction watchdog. Init steps retry
//                   once before ERROR; host steps are acked with o_err set.
//                   When undefined, o_err is tied low and the FSM waits
//                   indefinitely.
module adxl357_i2c_sequencer #(
  parameter logic [6:0]  P_DEV_ADDR    = 7'h1D,
  parameter logic [2:0]  P_CLK_RATE    = 3'd6,
  parameter logic [7:0]  P_RANGE       = 8'h81,
  parameter logic [7:0]  P_FILTER      = 8'h00,
  parameter logic [15:0] P_PWRUP_CYC   = 16'd50000,
  parameter logic [19:0] P_TIMEOUT_CYC = 20'd500000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_drdy,
  input  logic [31:0] i_status,
  input  logic        i_host_req,
  input  logic [7:0]  i_host_reg,
  input  logic [7:0]  i_host_data,
  output logic [31:0] o_ctrl,
  output logic [6:0]  o_dev_addr,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_w_data,
  output logic        o_drdy,
  output logic        o_init_done,
  output logic        o_host_ack,
  output logic        o_err,
  output logic [15:0] o_sample_cnt,
  output logic [3:0]  o_seq_state
);

  localparam logic [1:0] MODE_CPU   = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [3:0] {
    S_PWRUP      = 4'd0,
    S_INIT_ISSUE = 4'd1,
    S_INIT_BUSY  = 4'd2,
    S_INIT_DONE  = 4'd3,
    S_RUN        = 4'd4,
    S_HOST_DRAIN = 4'd5,
    S_HOST_ISSUE = 4'd6,
    S_HOST_BUSY  = 4'd7,
    S_HOST_DONE  = 4'd8,
    S_ERROR      = 4'd9
  } state_t;

  // {register, value} for each init step; idx 2 starts measurement.
  function automatic logic [15:0] init_entry(input logic [1:0] i);
    case (i)
      2'd0:    init_entry = {8'h2C, P_RANGE};
      2'd1:    init_entry = {8'h28, P_FILTER};
      default: init_entry = {8'h2D, 8'h00};
    endcase
  endfunction

  state_t      state, state_nx;
  logic [1:0]  rdy_sync, fin_sync;
  logic        fin_d, idle_cond, idle_cond_d, idle, fin_rise;
  logic        drdy_d, drdy_rise;
  logic [19:0] cnt, cnt_nx;
  logic [1:0]  idx, idx_nx, mode, mode_nx;
  logic        en, en_nx;
  logic [7:0]  reg_addr, reg_addr_nx, w_data, w_data_nx;
  logic        init_done, init_done_nx, host_ack, host_ack_nx;
  logic        pend, pend_nx, ret, ret_nx;
  logic        host_take, gate_open, host_path, drdy_out;
  logic [15:0] sample_cnt;
  logic        unused_cfg;
`ifdef SEQ_TIMEOUT_EN
  logic        err, err_nx, retry, retry_nx;
  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

  assign unused_cfg = ^{P_TIMEOUT_CYC, i_status[31:10]};

  // Status synchroniser; the controller state bits are used as-is.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdy_sync    <= 2'b00;
      fin_sync    <= 2'b00;
      fin_d       <= 1'b0;
      idle_cond_d <= 1'b0;
      drdy_d      <= 1'b0;
    end else begin
      rdy_sync    <= {rdy_sync[0], i_status[0]};
      fin_sync    <= {fin_sync[0], i_status[1]};
      fin_d       <= fin_sync[1];
      idle_cond_d <= idle_cond;
      drdy_d      <= i_drdy;
    end
  end

  assign idle_cond = rdy_sync[1] && (i_status[9:2] == 8'h00);
  assign idle      = idle_cond && idle_cond_d;
  assign fin_rise  = fin_sync[1] && !fin_d;
  assign drdy_rise = i_drdy && !drdy_d;

  // FSM and control registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_PWRUP;
      cnt        <= '0;
      idx        <= '0;
      mode       <= MODE_CPU;
      en         <= 1'b0;
      reg_addr   <= '0;
      w_data     <= '0;
      init_done  <= 1'b0;
      host_ack   <= 1'b0;
      pend       <= 1'b0;
      ret        <= 1'b0;
      sample_cnt <= '0;
`ifdef SEQ_TIMEOUT_EN
      err        <= 1'b0;
      retry      <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      mode      <= mode_nx;
      en        <= en_nx;
      reg_addr  <= reg_addr_nx;
      w_data    <= w_data_nx;
      init_done <= init_done_nx;
      host_ack  <= host_ack_nx;
      pend      <= pend_nx;
      ret       <= ret_nx;
      // Only finishes seen in burst mode are sample reads.
      if (fin_rise && mode == MODE_BURST) sample_cnt <= sample_cnt + 16'd1;
`ifdef SEQ_TIMEOUT_EN
      err       <= err_nx;
      retry     <= retry_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    idx_nx       = idx;
    mode_nx      = mode;
    en_nx        = en;
    reg_addr_nx  = reg_addr;
    w_data_nx    = w_data;
    init_done_nx = init_done;
    host_ack_nx  = 1'b0;
    ret_nx       = 1'b0;
    pend_nx      = pend;
`ifdef SEQ_TIMEOUT_EN
    err_nx       = err;
    retry_nx     = retry;
`endif
    // The ack cycle ignores a request the host has not yet dropped.
    host_take = (state == S_RUN) && i_host_req && !host_ack;
    gate_open = (state == S_RUN) && !host_take;
    host_path = host_take ||
                (state inside {S_HOST_DRAIN, S_HOST_ISSUE, S_HOST_BUSY, S_HOST_DONE});
    drdy_out  = gate_open && (i_drdy || (ret && pend));
    if (gate_open && ret)                          pend_nx = 1'b0;
    else if (!gate_open && drdy_rise && host_path) pend_nx = 1'b1;

    case (state)
      S_PWRUP: begin
        if (cnt == {4'b0, P_PWRUP_CYC}) begin
          idx_nx   = '0;
          state_nx = S_INIT_ISSUE;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_INIT_ISSUE: if (idle) begin
        {reg_addr_nx, w_data_nx} = init_entry(idx);
        mode_nx  = MODE_CPU;
        en_nx    = 1'b1;
        state_nx = S_INIT_BUSY;
      end
      S_INIT_BUSY: if (!rdy_sync[1]) begin
        en_nx    = 1'b0;
        state_nx = S_INIT_DONE;
      end
      S_INIT_DONE: if (idle) begin
        if (idx == 2'd2) begin
          init_done_nx = 1'b1;
          mode_nx      = MODE_BURST;
          state_nx     = S_RUN;
        end else begin
          idx_nx   = idx + 2'd1;
`ifdef SEQ_TIMEOUT_EN
          retry_nx = 1'b0;
`endif
          state_nx = S_INIT_ISSUE;
        end
      end
      S_RUN: if (host_take) state_nx = S_HOST_DRAIN;
      S_HOST_DRAIN: if (idle) begin
        mode_nx  = MODE_CPU;
        state_nx = S_HOST_ISSUE;
      end
      S_HOST_ISSUE: if (idle) begin
        reg_addr_nx = i_host_reg;
        w_data_nx   = i_host_data;
        en_nx       = 1'b1;
        state_nx    = S_HOST_BUSY;
      end
      S_HOST_BUSY: if (!rdy_sync[1]) begin
        en_nx    = 1'b0;
        state_nx = S_HOST_DONE;
      end
      S_HOST_DONE: if (idle) begin
        host_ack_nx = 1'b1;
        mode_nx     = MODE_BURST;
        ret_nx      = 1'b1;
        state_nx    = S_RUN;
      end
      default: ;
    endcase

    if (state_nx != state) cnt_nx = '0;

`ifdef SEQ_TIMEOUT_EN
    if (state inside {S_INIT_BUSY, S_INIT_DONE, S_HOST_DRAIN, S_HOST_BUSY, S_HOST_DONE}) begin
      if (cnt >= P_TIMEOUT_CYC) begin
        err_nx = 1'b1;
        en_nx  = 1'b0;
        cnt_nx = '0;
        if (state == S_INIT_BUSY || state == S_INIT_DONE) begin
          retry_nx = 1'b1;
          state_nx = retry ? S_ERROR : S_INIT_ISSUE;
        end else begin
          host_ack_nx = 1'b1;
          mode_nx     = MODE_BURST;
          ret_nx      = 1'b1;
          state_nx    = S_RUN;
        end
      end else if (state_nx == state) begin
        cnt_nx = cnt + 20'd1;
      end
    end
`endif
  end

  assign o_ctrl       = {25'b0, P_CLK_RATE, mode, 1'b0, en};
  assign o_dev_addr   = P_DEV_ADDR;
  assign o_reg_addr   = reg_addr;
  assign o_w_data     = w_data;
  assign o_drdy       = drdy_out;
  assign o_init_done  = init_done;
  assign o_host_ack   = host_ack;
  assign o_sample_cnt = sample_cnt;
  assign o_seq_state  = state;

endmodule

// File: tb/tb_adxl357_i2c_sequencer.sv
module tb_adxl357_i2c_sequencer;

  localparam logic [3:0] ST_PWRUP = 4'd0, ST_INIT_BUSY = 4'd2, ST_RUN = 4'd4, ST_ERROR = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drdy = 1'b0;
  logic        host_req = 1'b0;
  logic [7:0]  host_reg = 8'h00, host_data = 8'h00;
  logic [31:0] status;
  logic [31:0] ctrl;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr, w_data;
  logic        drdy_o, init_done, host_ack, err;
  logic [15:0] sample_cnt;
  logic [3:0]  seq_state;

  int n_vec = 0, n_err = 0;

  // Controller model
  logic        m_ready = 1'b1;
  logic [7:0]  m_state = 8'h00;
  logic        m_fin = 1'b0;
  int          m_cnt = 0;
  logic        drdy_prev = 1'b0, en_prev = 1'b0;
  logic [7:0]  wr_reg [64];
  logic [7:0]  wr_dat [64];
  logic [1:0]  wr_mode[64];
  int          wr_n = 0, bursts = 0, en_rise_ign = 0;
  logic [7:0]  ignore_reg = 8'hFF;

  int base_wr, base_b, b_at_ack, acks, viol, pre, post, found, base_ign;
  logic en_p;

  assign status = {22'b0, m_state, m_fin, m_ready};

  adxl357_i2c_sequencer #(
    .P_PWRUP_CYC  (16'd20),
    .P_TIMEOUT_CYC(20'd200)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_drdy      (drdy),
    .i_status    (status),
    .i_host_req  (host_req),
    .i_host_reg  (host_reg),
    .i_host_data (host_data),
    .o_ctrl      (ctrl),
    .o_dev_addr  (dev_addr),
    .o_reg_addr  (reg_addr),
    .o_w_data    (w_data),
    .o_drdy      (drdy_o),
    .o_init_done (init_done),
    .o_host_ack  (host_ack),
    .o_err       (err),
    .o_sample_cnt(sample_cnt),
    .o_seq_state (seq_state)
  );

  always #5 clk = ~clk;

  // Writes take 6 cycles, bursts 8; both end with a one-cycle finish.
  always @(posedge clk) begin
    drdy_prev <= drdy_o;
    en_prev   <= ctrl[0];
    m_fin     <= 1'b0;
    if (ctrl[0] && !en_prev && reg_addr == ignore_reg) en_rise_ign <= en_rise_ign + 1;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_state <= 8'h00;
        m_fin   <= 1'b1;
      end
    end else if (ctrl[0] && m_ready && m_state == 8'h00 && reg_addr != ignore_reg) begin
      wr_reg[wr_n]  <= reg_addr;
      wr_dat[wr_n]  <= w_data;
      wr_mode[wr_n] <= ctrl[3:2];
      wr_n          <= wr_n + 1;
      m_ready       <= 1'b0;
      m_state       <= 8'h11;
      m_cnt         <= 6;
    end else if (drdy_o && !drdy_prev && ctrl[3:2] == 2'b10) begin
      bursts  <= bursts + 1;
      m_ready <= 1'b0;
      m_state <= 8'h22;
      m_cnt   <= 8;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (init_done) break;
      @(negedge clk);
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ctrl"},  ctrl, 32'h0000_0060);
    check({pfx, "_dev"},   32'(dev_addr), 32'h1D);
    check({pfx, "_addr"},  32'(reg_addr), 32'h0);
    check({pfx, "_wdata"}, 32'(w_data), 32'h0);
    check({pfx, "_state"}, 32'(seq_state), 32'(ST_PWRUP));
    check({pfx, "_cnt"},   32'(sample_cnt), 32'h0);
    check({pfx, "_flags"}, 32'({drdy_o, init_done, host_ack, err}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    cyc(3);
    check_reset_vals("rst");

    // Init table
    rst = 1'b0;
    wait_init("init_done");
    check("init_nwr", 32'(wr_n), 32'd3);
    check("init0", 32'({wr_reg[0], wr_dat[0]}), 32'h2C81);
    check("init1", 32'({wr_reg[1], wr_dat[1]}), 32'h2800);
    check("init2", 32'({wr_reg[2], wr_dat[2]}), 32'h2D00);
    check("init_modes", 32'({wr_mode[0], wr_mode[1], wr_mode[2]}), 32'h0);
    check("run_ctrl", ctrl, 32'h0000_0068);
    check("run_state", 32'(seq_state), 32'(ST_RUN));

    // Five bursts
    cyc(2);
    drdy = 1'b1;
    #1;
    check("drdy_pass", 32'(drdy_o), 32'd1);
    @(negedge clk);
    drdy = 1'b0;
    cyc(20);
    for (int k = 0; k < 4; k++) begin
      drdy = 1'b1;
      @(negedge clk);
      drdy = 1'b0;
      cyc(20);
    end
    check("cnt5", 32'(sample_cnt), 32'd5);
    check("bursts5", 32'(bursts), 32'd5);

    // Counter wrap
    force dut.sample_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt;
    @(negedge clk);
    check("preset", 32'(sample_cnt), 32'h0000_FFFF);
    drdy = 1'b1;
    @(negedge clk);
    drdy = 1'b0;
    cyc(20);
    check("wrap", 32'(sample_cnt), 32'h0);

    // Host write requested mid-burst
    drdy = 1'b1;
    @(negedge clk);
    drdy = 1'b0;
    cyc(3);
    base_wr = wr_n;
    base_b  = bursts;
    host_reg = 8'h2D; host_data = 8'h01; host_req = 1'b1;
    viol = 0; acks = 0; en_p = ctrl[0];
    for (int i = 0; i < 300 && acks == 0; i++) begin
      @(negedge clk);
      if (ctrl[0] && !en_p && !(m_ready && m_state == 8'h00)) viol++;
      en_p = ctrl[0];
      if (host_ack) begin
        acks++;
        host_req = 1'b0;
      end
    end
    check("host_ack", 32'(acks), 32'd1);
    check("host_no_early_en", 32'(viol), 32'd0);
    check("host_nwr", 32'(wr_n), 32'(base_wr + 1));
    check("host_wr", 32'({wr_mode[base_wr], wr_reg[base_wr], wr_dat[base_wr]}), 32'h02D01);
    check("host_bursts", 32'(bursts), 32'(base_b));
    check("host_cnt", 32'(sample_cnt), 32'd1);
    @(negedge clk);
    check("ack_1cyc", 32'(host_ack), 32'd0);
    check("host_opmode", 32'(ctrl[3:2]), 32'd2);

    // DRDY and host request in the same cycle
    cyc(5);
    base_wr = wr_n;
    base_b  = bursts;
    pre = 0; post = 0; acks = 0; b_at_ack = -1;
    host_reg = 8'h2D; host_data = 8'h00; host_req = 1'b1; drdy = 1'b1;
    #1;
    check("simul_gated", 32'(drdy_o), 32'd0);
    @(negedge clk);
    drdy = 1'b0;
    for (int i = 0; i < 300 && acks == 0; i++) begin
      if (host_ack) begin
        acks++;
        host_req = 1'b0;
        b_at_ack = bursts;
      end
      if (drdy_o) begin
        if (acks != 0) post++;
        else pre++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      if (drdy_o) post++;
      @(negedge clk);
    end
    check("simul_ack", 32'(acks), 32'd1);
    check("simul_pre", 32'(pre), 32'd0);
    check("simul_replay", 32'(post), 32'd1);
    check("simul_wr", 32'({wr_reg[base_wr], wr_dat[base_wr]}), 32'h2D00);
    check("simul_b_ack", 32'(b_at_ack), 32'(base_b));
    check("simul_bursts", 32'(bursts), 32'(base_b + 1));
    check("simul_cnt", 32'(sample_cnt), 32'd2);

    // Reset during INIT_BUSY idx 2
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (seq_state == ST_INIT_BUSY && reg_addr == 8'h2D) begin
        found = 1;
        break;
      end
    end
    check("reach_busy2", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    cyc(2);
    rst = 1'b0;
    base_wr = wr_n;
    wait_init("reinit_done");
    check("reinit_nwr", 32'(wr_n), 32'(base_wr + 3));
    check("reinit0", 32'(wr_reg[base_wr]), 32'h2C);
    check("reinit1", 32'(wr_reg[base_wr + 1]), 32'h28);
    check("reinit2", 32'(wr_reg[base_wr + 2]), 32'h2D);

`ifdef SEQ_TIMEOUT_EN
    // Controller never goes busy for FILTER
    rst = 1'b1;
    ignore_reg = 8'h28;
    cyc(2);
    base_ign = en_rise_ign;
    base_wr  = wr_n;
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (seq_state == ST_ERROR) begin
        found = 1;
        break;
      end
    end
    check("to_error", 32'(found), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_attempts", 32'(en_rise_ign - base_ign), 32'd2);
    check("to_nwr", 32'(wr_n - base_wr), 32'd1);
    drdy = 1'b1;
    #1;
    check("to_drdy_low", 32'(drdy_o), 32'd0);
    check("to_no_init", 32'({init_done, ctrl[0]}), 32'd0);
    @(negedge clk);
    drdy = 1'b0;
    cyc(5);
    check("to_stay", 32'(seq_state), 32'(ST_ERROR));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
